// File: rtl/ioctl_port1_bridge.sv
// Bridges the data_io download/upload byte stream onto SDRAM port 1 (toggle req/ack).
// Downloads are nibble-expanded and queued in a 2-entry FIFO; uploads read back NVRAM bytes.
module ioctl_port1_bridge #(
    parameter logic [22:0] CMOS_BASE = 23'h1CC00,
    parameter logic [7:0]  NV_INDEX  = 8'hFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_din,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    input  logic [15:0] port1_q,
    output logic        rom_loaded,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;
    typedef enum logic [1:0] {OpNone, OpWrite, OpRead} op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        wr_q, wr_d;
    logic        dl_q, dl_d;
    logic        up_q, up_d;
    logic        idx0_q, idx0_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [22:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [7:0]  din_q, din_d;
    logic        pend_q, pend_d;
    logic [9:0]  last_q, last_d;
    logic        rom_q, rom_d;
    logic        ovr_q, ovr_d;
    logic [38:0] fifo_q [2];
    logic [38:0] fifo_d [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        cmos_hit;
    logic [22:0] map_addr;
    logic [15:0] exp_data;
    logic        push, push_ok, pop, done, full;
    logic        dl_rise, up_rise, need, pend;

    always_comb begin
        cmos_hit = ((ioctl_index == 8'h00) && (ioctl_addr[22:10] == 13'h034)) ||
                   (ioctl_index == NV_INDEX);
        map_addr = cmos_hit ? (CMOS_BASE | {13'd0, ioctl_addr[9:0]}) : ioctl_addr[22:0];
        exp_data = {ioctl_dout[7:4], ioctl_dout[7:4], ioctl_dout[3:0], ioctl_dout[3:0]};
    end

    always_comb begin
        push    = ioctl_download && ioctl_wr && !wr_q;
        dl_rise = ioctl_download && !dl_q;
        up_rise = ioctl_upload && !up_q;
        done    = (state_q == StWait) && (port1_ack == req_q);
        pop     = done && (op_q == OpWrite);
        full    = (cnt_q == 2'd2);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push_ok = push && (!full || pop);
        need    = up_rise || (ioctl_upload && (ioctl_addr[9:0] != last_q));
        pend    = pend_q || need;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wr_d    = ioctl_wr;
        dl_d    = ioctl_download;
        up_d    = ioctl_upload;
        idx0_d  = idx0_q;
        req_d   = req_q;
        we_d    = we_q;
        a_d     = a_q;
        d_d     = d_q;
        din_d   = din_q;
        pend_d  = pend;
        last_d  = last_q;
        rom_d   = rom_q;
        ovr_d   = ovr_q;
        fifo_d  = fifo_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;

        if (push_ok) begin
            fifo_d[wptr_q] = {map_addr, exp_data};
            wptr_d         = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - 2'd1;
        end

        if (dl_rise) begin
            ovr_d  = 1'b0;
            idx0_d = (ioctl_index == 8'h00);
        end
        if (push && !push_ok) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (cnt_q != 2'd0) begin
                    {a_d, d_d} = fifo_q[rptr_q];
                    we_d       = 1'b1;
                    req_d      = ~req_q;
                    op_d       = OpWrite;
                    state_d    = StWait;
                end else if (pend && ioctl_upload) begin
                    a_d     = map_addr;
                    we_d    = 1'b0;
                    req_d   = ~req_q;
                    op_d    = OpRead;
                    last_d  = ioctl_addr[9:0];
                    pend_d  = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // OpNone here is the stale post-reset transaction; just let it drain.
                if (port1_ack == req_q) begin
                    if (op_q == OpRead) begin
                        din_d = {port1_q[11:8], port1_q[3:0]};
                    end
                    op_d    = OpNone;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (dl_rise) begin
            rom_d = 1'b0;
        end else if (!ioctl_download && (cnt_q == 2'd0) && (state_q == StIdle) && idx0_q) begin
            rom_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StWait;
            op_q      <= OpNone;
            wr_q      <= 1'b0;
            dl_q      <= 1'b0;
            up_q      <= 1'b0;
            idx0_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            din_q     <= '0;
            pend_q    <= 1'b0;
            last_q    <= '0;
            rom_q     <= 1'b0;
            ovr_q     <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            dl_q      <= dl_d;
            up_q      <= up_d;
            idx0_q    <= idx0_d;
            req_q     <= req_d;
            we_q      <= we_d;
            a_q       <= a_d;
            d_q       <= d_d;
            din_q     <= din_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            rom_q     <= rom_d;
            ovr_q     <= ovr_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ioctl_din  = din_q;
        port1_req  = req_q;
        port1_a    = a_q;
        port1_ds   = 2'b11;
        port1_we   = we_q;
        port1_d    = d_q;
        rom_loaded = rom_q;
        overrun    = ovr_q;
        busy       = (cnt_q != 2'd0) || (op_q != OpNone);
    end

endmodule

// File: tb/tb_ioctl_port1_bridge.sv
// Directed bench for ioctl_port1_bridge: an SDRAM ack responder plus a scoreboard of
// expected port1 transactions checked at each req toggle and again when ack matches.
module tb_ioctl_port1_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_din;
    logic        port1_req;
    logic        port1_ack = 1'b0;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port1_we;
    logic [15:0] port1_d;
    logic [15:0] port1_q = '0;
    logic        rom_loaded;
    logic        busy;
    logic        overrun;

    ioctl_port1_bridge dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_we       (port1_we),
        .port1_d        (port1_d),
        .port1_q        (port1_q),
        .rom_loaded     (rom_loaded),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [22:0] a;
        logic [15:0] d;
        logic        we;
    } txn_t;

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   toggles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SDRAM responder: auto mode mirrors req after ack_delay cycles, manual mode forces ack.
    bit   sd_auto = 1'b1;
    logic ack_man = 1'b0;
    int   ack_delay = 3;
    int   dly = 0;
    always @(posedge clk_sys) begin
        if (!sd_auto) begin
            port1_ack <= ack_man;
            dly       <= 0;
        end else if (port1_ack != port1_req) begin
            if (dly >= ack_delay) begin
                port1_ack <= port1_req;
                dly       <= 0;
            end else begin
                dly <= dly + 1;
            end
        end else begin
            dly <= 0;
        end
    end

    // Scoreboard monitor.
    logic        req_prev = 1'b0;
    bit          outstanding = 1'b0;
    logic [22:0] cap_a;
    logic [15:0] cap_d;
    logic        cap_we;
    txn_t        mon_e;
    always @(posedge clk_sys) begin
        #1;
        if (!reset_n) begin
            req_prev    = 1'b0;
            outstanding = 1'b0;
        end else begin
            if (port1_req !== req_prev) begin
                toggles++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(port1_a), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("txn_addr", 32'(port1_a), 32'(mon_e.a));
                    check("txn_we", 32'(port1_we), 32'(mon_e.we));
                    if (mon_e.we) check("txn_data", 32'(port1_d), 32'(mon_e.d));
                end
                cap_a       = port1_a;
                cap_d       = port1_d;
                cap_we      = port1_we;
                outstanding = 1'b1;
            end else if (outstanding && (port1_ack === port1_req)) begin
                check("hold_addr", 32'(port1_a), 32'(cap_a));
                check("hold_data", 32'(port1_d), 32'(cap_d));
                check("hold_we", 32'(port1_we), 32'(cap_we));
                outstanding = 1'b0;
            end
            req_prev = port1_req;
        end
    end

    task automatic wr_byte(input logic [24:0] addr, input logic [7:0] dat, input bit accept,
                           input logic [22:0] ea, input logic [15:0] ed);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_dout = dat;
        ioctl_wr   = 1'b1;
        if (accept) exp_q.push_back('{ea, ed, 1'b1});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        @(posedge clk_sys);
        #1;
        while (busy && (n < max_cycles)) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_ack_state(input logic match, input int max_cycles);
        int n;
        n = 0;
        @(posedge clk_sys);
        #1;
        while (((port1_ack === port1_req) != match) && (n < max_cycles)) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        check("ack_wait_timeout", 32'(port1_ack === port1_req), 32'(match));
    endtask

    int tog_snap;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk_sys);
        check("rst_req", 32'(port1_req), 32'd0);
        check("rst_we", 32'(port1_we), 32'd0);
        check("rst_a", 32'(port1_a), 32'd0);
        check("rst_d", 32'(port1_d), 32'd0);
        check("rst_ds", 32'(port1_ds), 32'd3);
        check("rst_din", 32'(ioctl_din), 32'd0);
        check("rst_rom", 32'(rom_loaded), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Plain and CMOS-remapped writes, index 0 download.
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        wr_byte(25'h0000100, 8'hA5, 1'b1, 23'h000100, 16'hAA55);
        wait_idle(50);
        check("one_toggle", 32'(toggles), 32'd1);
        wr_byte(25'h000D3FF, 8'h12, 1'b1, 23'h01CFFF, 16'h1122);
        wait_idle(50);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rom_set_idx0", 32'(rom_loaded), 32'd1);

        // NVRAM index remap; new download clears rom_loaded and does not re-set it.
        ioctl_index    = 8'hFF;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("rom_clr_rise", 32'(rom_loaded), 32'd0);
        wr_byte(25'h0000002, 8'h7E, 1'b1, 23'h01CC02, 16'h77EE);
        wait_idle(50);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rom_stays_nv", 32'(rom_loaded), 32'd0);

        // Overrun: slow ack, third write finds the FIFO full.
        ack_delay      = 40;
        ioctl_download = 1'b1;
        wr_byte(25'h0000010, 8'h01, 1'b1, 23'h01CC10, 16'h0011);
        repeat (2) @(negedge clk_sys);
        wr_byte(25'h0000011, 8'h02, 1'b1, 23'h01CC11, 16'h0022);
        repeat (2) @(negedge clk_sys);
        check("no_ovr_yet", 32'(overrun), 32'd0);
        wr_byte(25'h0000012, 8'h03, 1'b0, 23'h0, 16'h0);
        @(negedge clk_sys);
        check("ovr_set", 32'(overrun), 32'd1);
        wait_idle(300);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("ovr_sticky", 32'(overrun), 32'd1);
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("ovr_clr", 32'(overrun), 32'd0);
        ioctl_download = 1'b0;
        ack_delay      = 3;
        repeat (2) @(negedge clk_sys);

        // Upload reads.
        port1_q    = 16'h0C03;
        ioctl_addr = 25'h0000000;
        exp_q.push_back('{23'h01CC00, 16'h0, 1'b0});
        ioctl_upload = 1'b1;
        wait_idle(50);
        check("rd0_din", 32'(ioctl_din), 32'hC3);
        @(negedge clk_sys);
        ioctl_addr = 25'h0000001;
        exp_q.push_back('{23'h01CC01, 16'h0, 1'b0});
        wait_idle(50);
        check("rd1_din", 32'(ioctl_din), 32'hC3);
        @(negedge clk_sys);
        port1_q    = 16'h5A69;
        ioctl_addr = 25'h0000002;
        exp_q.push_back('{23'h01CC02, 16'h0, 1'b0});
        wait_idle(50);
        check("rd2_din", 32'(ioctl_din), 32'hA9);
        repeat (3) @(negedge clk_sys);
        check("rd_no_extra", 32'(toggles), 32'd8);
        ioctl_upload = 1'b0;

        // Reset mid-transaction with a stale ack.
        @(negedge clk_sys);
        ack_man        = port1_ack;
        sd_auto        = 1'b0;
        ioctl_download = 1'b1;
        wr_byte(25'h0000005, 8'h3C, 1'b1, 23'h01CC05, 16'h33CC);
        repeat (3) @(negedge clk_sys);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mrst_req", 32'(port1_req), 32'd0);
        check("mrst_we", 32'(port1_we), 32'd0);
        check("mrst_a", 32'(port1_a), 32'd0);
        check("mrst_din", 32'(ioctl_din), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        ack_man = 1'b1;
        @(negedge clk_sys);
        reset_n  = 1'b1;
        tog_snap = toggles;
        repeat (6) @(negedge clk_sys);
        check("stale_no_req", 32'(port1_req), 32'd0);
        wr_byte(25'h0000006, 8'h81, 1'b1, 23'h01CC06, 16'h8811);
        repeat (4) @(negedge clk_sys);
        check("stale_hold_req", 32'(port1_req), 32'd0);
        check("stale_no_tog", 32'(toggles), 32'(tog_snap));
        ack_delay = 2;
        sd_auto   = 1'b1;
        wait_ack_state(1'b0, 50);
        wait_ack_state(1'b1, 50);
        wait_idle(50);
        check("post_rst_tog", 32'(toggles), 32'(tog_snap + 1));
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);

        // rom_loaded waits for the FIFO to drain after the download ends.
        ack_delay      = 10;
        ioctl_index    = 8'h00;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        wr_byte(25'h0000200, 8'h4B, 1'b1, 23'h000200, 16'h44BB);
        wr_byte(25'h0000201, 8'hC7, 1'b1, 23'h000201, 16'hCC77);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("rom_not_at_fall", 32'(rom_loaded), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        wait_ack_state(1'b1, 50);
        wait_ack_state(1'b0, 50);
        wait_ack_state(1'b1, 50);
        check("rom_at_ack", 32'(rom_loaded), 32'd0);
        @(posedge clk_sys);
        #1;
        check("rom_ack_p1", 32'(rom_loaded), 32'd0);
        check("idle_ack_p1", 32'(busy), 32'd0);
        @(posedge clk_sys);
        #1;
        check("rom_ack_p2", 32'(rom_loaded), 32'd1);

        repeat (5) @(negedge clk_sys);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
